regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file with a per-register pending-write scoreboard.
- Replaces the bare register array and ad-hoc write-back logic in the core.
- Supports multi-cycle producers (loads, long ALU ops). The issue logic stalls on RAW/WAW hazards. Same-cycle write-back data is bypassed to the read ports.

Parameters:
XLEN, 64, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >= 2)
REG_AW, $clog2(NUM_REGS), register address width (derived, not overridden)
X0_ZERO, 1, when 1 register 0 reads as zero and is never written or marked pending

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode presents an instruction this cycle
issue_ready  out  1  no hazard; instruction may issue
issue_rs1  in  REG_AW  source register 1 index
issue_rs2  in  REG_AW  source register 2 index
issue_use_rs1  in  1  instruction reads rs1
issue_use_rs2  in  1  instruction reads rs2
issue_rd  in  REG_AW  destination index
issue_writes_rd  in  1  instruction will write rd later
rs1_val  out  XLEN  read data for issue_rs1
rs2_val  out  XLEN  read data for issue_rs2
wb_valid  in  1  write-back request
wb_rd  in  REG_AW  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  discard all outstanding pending marks (branch redirect)
pending_mask  out  NUM_REGS  current scoreboard bits, bit i = register i pending
wb_err  out  1  registered one-cycle pulse: write-back to non-pending register

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, pending_mask = 0, wb_err = 0. Reset released mid-operation discards all in-flight state.
- Reads are combinational.
  - If wb_valid and wb_rd == rsN and rsN is not the hardwired x0, rsN_val = wb_data (bypass).
  - Otherwise rsN_val = stored value.
  - x0 reads return 0 when X0_ZERO = 1.
- Hazard (combinational): hazard exists if any of the following hold:
  - issue_use_rs1 and pending[rs1], and rs1 not being cleared by wb this cycle;
  - the same condition for rs2;
  - issue_writes_rd and pending[rd], and rd not being cleared this cycle (WAW).
- issue_ready = !hazard. It is independent of issue_valid. It is forced to 0 while flush = 1.
- Issue fire = issue_valid && issue_ready.
  - On fire with issue_writes_rd and rd != hardwired x0, pending[rd] is set at the next edge.
- Write-back: on wb_valid with wb_rd != hardwired x0:
  - the register is written at the next edge;
  - pending[wb_rd] is cleared.
- Write-back with pending[wb_rd] = 0: the data is still written, and wb_err pulses high for exactly the following cycle.
- Write-back to x0 (X0_ZERO = 1): ignored silently; no wb_err.
- Simultaneous issue and write-back to the same rd: the write-back data is written and the pending bit ends SET (the new producer wins).
- flush: all pending bits clear at the next edge. A concurrent wb still writes data and does not raise wb_err. A concurrent issue does not fire.
- No other state. Latency: write visible to reads via bypass in the same cycle, and from storage from the next cycle.

Decomposition:
- Shared package core_pkg:
  - XLEN default;
  - REG_AW derivation function;
  - the constant for the x0 index;
  - a typedef for the register index.
- One natural sub-module, scoreboard_bits: owns the pending vector, set/clear/flush priority, and wb_err generation.
- The top holds the storage array, the bypass muxes and the hazard equation.

Test Plan:
- Reset mid-run: write x5 = 0xAA, assert rst_n low asynchronously -> x5 reads 0, pending_mask = 0, wb_err = 0 immediately.
- RAW stall: issue rd = 3 with writes_rd -> pending_mask[3] = 1. Next cycle issue with rs1 = 3 -> issue_ready = 0. Then wb_rd = 3, wb_data = 15 in the same cycle -> issue_ready = 1 and rs1_val = 15 (bypass). The next cycle reads 15 from storage.
- WAW and same-rd collision: with pending[4] set, wb_rd = 4 and an issue with rd = 4 in the same cycle -> x4 holds the wb data and pending_mask[4] remains 1.
- x0 handling: wb_rd = 0, wb_data = 0x1234 -> reads of x0 return 0. Issue rd = 0 -> pending_mask[0] never set. No wb_err.
- Spurious write-back: wb_rd = 7 with pending[7] = 0, data 20 -> x7 = 20 and wb_err high for exactly one cycle.
- Flush: pending bits 1, 2, 9 set, flush = 1 with wb_rd = 2, wb_data = 5 -> next cycle pending_mask = 0, x2 = 5, no wb_err, and issue_ready = 0 during the flush cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, register-index helpers and the x0 index.
package core_pkg;

   localparam int XLEN_DEFAULT     = 64;
   localparam int NUM_REGS_DEFAULT = 32;
   localparam int X0_IDX           = 0;

   // Address width for a register file of n entries; a single-entry file still needs one bit.
   function automatic int reg_aw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef logic [reg_aw(NUM_REGS_DEFAULT)-1:0] reg_idx_t;

endpackage

// File: rtl/scoreboard_bits.sv
// Pending-write scoreboard: one bit per register plus the spurious write-back flag.
module scoreboard_bits import core_pkg::*; #(
   parameter int NUM_REGS = NUM_REGS_DEFAULT,
   localparam int REG_AW  = reg_aw(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_en,
   input  logic [REG_AW-1:0]   set_idx,
   input  logic                clr_en,
   input  logic [REG_AW-1:0]   clr_idx,
   input  logic                flush,
   output logic [NUM_REGS-1:0] pending,
   output logic                wb_err
);

   logic [NUM_REGS-1:0] pending_nxt;
   logic                wb_err_nxt;

   // Priority: clear from write-back, then set from issue (new producer wins), flush overrides both.
   always_comb begin
      pending_nxt = pending;
      if (clr_en) pending_nxt[clr_idx] = 1'b0;
      if (set_en) pending_nxt[set_idx] = 1'b1;
      if (flush)  pending_nxt = '0;
      wb_err_nxt = clr_en && !pending[clr_idx] && !flush;
   end

   // Scoreboard and error-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         wb_err  <= 1'b0;
      end else begin
         pending <= pending_nxt;
         wb_err  <= wb_err_nxt;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-back bypass and RAW/WAW hazard detection.
module regfile_scoreboard import core_pkg::*; #(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter int NUM_REGS = NUM_REGS_DEFAULT,
   parameter int X0_ZERO  = 1,
   localparam int REG_AW  = reg_aw(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic [REG_AW-1:0]   issue_rs1,
   input  logic [REG_AW-1:0]   issue_rs2,
   input  logic                issue_use_rs1,
   input  logic                issue_use_rs2,
   input  logic [REG_AW-1:0]   issue_rd,
   input  logic                issue_writes_rd,
   output logic [XLEN-1:0]     rs1_val,
   output logic [XLEN-1:0]     rs2_val,
   input  logic                wb_valid,
   input  logic [REG_AW-1:0]   wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                flush,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic                wb_err
);

   logic [XLEN-1:0] regs [NUM_REGS];
   logic            wb_we;
   logic            issue_fire;
   logic            hazard;

   // True only for the hardwired-zero register.
   function automatic logic is_x0(input logic [REG_AW-1:0] idx);
      return (X0_ZERO != 0) && (idx == REG_AW'(X0_IDX));
   endfunction

   assign wb_we = wb_valid && !is_x0(wb_rd);

   // Storage array; write-back lands at the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_we) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // Read ports: same-cycle write-back bypass, x0 forced to zero.
   always_comb begin
      rs1_val = regs[issue_rs1];
      rs2_val = regs[issue_rs2];
      if (wb_we && (wb_rd == issue_rs1)) rs1_val = wb_data;
      if (wb_we && (wb_rd == issue_rs2)) rs2_val = wb_data;
      if (is_x0(issue_rs1)) rs1_val = '0;
      if (is_x0(issue_rs2)) rs2_val = '0;
   end

   // Hazard: a needed register is pending and not being released by this cycle's write-back.
   always_comb begin
      hazard = 1'b0;
      if (issue_use_rs1 && pending_mask[issue_rs1] && !(wb_we && (wb_rd == issue_rs1)))
         hazard = 1'b1;
      if (issue_use_rs2 && pending_mask[issue_rs2] && !(wb_we && (wb_rd == issue_rs2)))
         hazard = 1'b1;
      if (issue_writes_rd && pending_mask[issue_rd] && !(wb_we && (wb_rd == issue_rd)))
         hazard = 1'b1;
      issue_ready = !hazard && !flush;
      issue_fire  = issue_valid && issue_ready;
   end

   scoreboard_bits #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (issue_fire && issue_writes_rd && !is_x0(issue_rd)),
      .set_idx (issue_rd),
      .clr_en  (wb_we),
      .clr_idx (wb_rd),
      .flush   (flush),
      .pending (pending_mask),
      .wb_err  (wb_err)
   );

endmodule
